// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared width defaults, fetch FSM encoding and prefetch-buffer entry layout
// for instr_fetch and its buffer.
package ifetch_pkg;
    localparam int ADDR_W_DEF  = 11;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } ifetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: circular prefetch buffer with synchronous push/pop/flush and occupancy count.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ifetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output entry_t        head_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // 2**PW slots so pointers wrap naturally; occupancy is still capped at DEPTH by the count.
    entry_t        mem_q [2**PW];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, push_en, pop_en;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && !flush_i && (!full || pop_en);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_q] <= push_data_i;
    end

    always_comb begin
        wr_d  = wr_q + PW'(push_en);
        rd_d  = rd_q + PW'(pop_en);
        cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding program-memory fetcher feeding a prefetch buffer.
// Define IFETCH_PREFETCH_EN for a DEPTH-entry buffer; otherwise the buffer holds one entry.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump_en,
    input  logic [7:0]         jump_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
);
`ifdef IFETCH_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif
    localparam int BUF_D = PREFETCH ? DEPTH : 1;
    localparam int CW    = $clog2(BUF_D + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    ifetch_state_t     state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d, oaddr_q;
    logic              disc_q, disc_d;
    logic              push, pop, empty, slots_ok;
    logic [CW-1:0]     count, count_nx;
    entry_t            push_data, head;

    assign pop      = !empty && instr_ready;
    assign push     = (state_q == WAIT) && mem_rvalid && !disc_q && !jump_en;
    // Occupancy after this edge; the outstanding request already holds its slot in the FSM.
    assign count_nx = jump_en ? '0 : count + CW'(push) - CW'(pop);
    assign slots_ok = (count_nx < CW'(BUF_D));

    assign push_data.pc    = oaddr_q;
    assign push_data.instr = mem_rdata;

    ifetch_fifo #(
        .DEPTH   (BUF_D),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (jump_en),
        .head_o      (head),
        .empty_o     (empty),
        .count_o     (count)
    );

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        disc_d  = disc_q;
        unique case (state_q)
            IDLE: if (slots_ok) state_d = REQ;
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                    if (!disc_q) fpc_d = fpc_q + 1'b1;
                end
                if (jump_en) disc_d = 1'b1;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    disc_d  = 1'b0;
                    state_d = slots_ok ? REQ : IDLE;
                end else if (jump_en) begin
                    disc_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jump_en) fpc_d = ADDR_W'(jump_addr);
    end

    // A request kept across a jump presents its original address until granted.
    assign mem_req  = (state_q == REQ);
    assign mem_addr = (mem_req && disc_q) ? oaddr_q : fpc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fpc_q   <= '0;
            disc_q  <= 1'b0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            disc_q  <= disc_d;
            if (mem_req) oaddr_q <= mem_addr;
        end
    end

    assign instr_valid = !empty;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;
endmodule
